pattern_detector_param: RTL and testbench

Parametrised serial pattern detector, successor to the fixed 5-bit detector. It adds:
- run-time loadable pattern and don't-care mask of PATT_W bits;
- overlapping and non-overlapping match modes;
- a serial_valid qualifier;
- a saturating match counter.
It sits on the serial bit stream after the deserialiser front end and flags matches to downstream control.

---
 rtl/pattern_detector_pkg.sv | 15 +
 rtl/sat_counter.sv | 23 ++
 rtl/pattern_detector_param.sv | 105 ++++++++++
 tb/tb_pattern_detector_param.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pattern_detector_pkg.sv
// rtl/pattern_detector_pkg.sv - shared types and helpers for the serial pattern detector
package pattern_detector_pkg;

    typedef enum logic [1:0] {
        UNLOADED = 2'd0,
        FILL     = 2'd1,
        ARMED    = 2'd2
    } pd_state_t;

    // Width needed to count 0..patt_w accepted bits
    function automatic int fill_width(input int patt_w);
        return $clog2(patt_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Clear wins over increment; increment stops at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_detector_param.sv
// rtl/pattern_detector_param.sv - serial pattern detector with loadable pattern/mask
module pattern_detector_param
    import pattern_detector_pkg::*;
#(
    parameter int PATT_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [PATT_W-1:0] pattern_in,
    input  logic [PATT_W-1:0] mask_in,
    input  logic              overlap_en,
    input  logic              serial_valid,
    input  logic              serial_in,
    input  logic              count_clr,
    output logic              patt,
    output logic [CNT_W-1:0]  match_count,
    output logic              armed
);

    localparam int FILL_W = fill_width(PATT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATT_W);

    pd_state_t           state_q, state_d;
    // Only the PATT_W-1 newest bits are kept: the oldest one is shifted out
    // before it could take part in the next comparison.
    logic [PATT_W-2:0]   history_q, history_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [PATT_W-1:0]   pattern_q, pattern_d;
    logic [PATT_W-1:0]   mask_q, mask_d;
    logic [PATT_W-1:0]   hist_next;
    logic [FILL_W-1:0]   fill_inc;
    logic                accept;
    logic                match;

    // State, history, pattern/mask and the registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= UNLOADED;
            history_q <= '0;
            fill_q    <= '0;
            pattern_q <= '0;
            mask_q    <= '0;
            patt      <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state_q   <= state_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            mask_q    <= mask_d;
            patt      <= match;
            armed     <= (state_d == ARMED);
        end
    end

    // Next-state, history shift and match evaluation; load overrides any serial bit
    always_comb begin
        state_d   = state_q;
        history_d = history_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        mask_d    = mask_q;
        match     = 1'b0;
        hist_next = {history_q, serial_in};
        fill_inc  = fill_q + 1'b1;
        accept    = serial_valid & ~load;

        if (load) begin
            pattern_d = pattern_in;
            mask_d    = mask_in;
            history_d = '0;
            fill_d    = '0;
            state_d   = FILL;
        end else if (accept && (state_q != UNLOADED)) begin
            history_d = hist_next[PATT_W-2:0];
            if (state_q == FILL) begin
                fill_d = fill_inc;
                if (fill_inc == FILL_FULL) begin
                    state_d = ARMED;
                end
            end
            // The bit that completes the history is compared in the same cycle
            if ((state_d == ARMED) && (((hist_next ^ pattern_q) & mask_q) == '0)) begin
                match = 1'b1;
                if (!overlap_en) begin
                    fill_d  = '0;
                    state_d = FILL;
                end
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .clr   (count_clr),
        .count (match_count)
    );

endmodule

// File: tb/tb_pattern_detector_param.sv
// tb/tb_pattern_detector_param.sv - directed self-checking bench for pattern_detector_param
module tb_pattern_detector_param;

    logic       clk;
    logic       reset;
    logic       load;
    logic [4:0] pattern_in;
    logic [4:0] mask_in;
    logic       overlap_en;
    logic       serial_valid;
    logic       serial_in;
    logic       count_clr;
    logic       patt;
    logic [7:0] match_count;
    logic       armed;
    logic       patt2;
    logic [1:0] match_count2;
    logic       armed2;

    int total = 0;
    int bad   = 0;

    pattern_detector_param #(.PATT_W(5), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .pattern_in   (pattern_in),
        .mask_in      (mask_in),
        .overlap_en   (overlap_en),
        .serial_valid (serial_valid),
        .serial_in    (serial_in),
        .count_clr    (count_clr),
        .patt         (patt),
        .match_count  (match_count),
        .armed        (armed)
    );

    pattern_detector_param #(.PATT_W(5), .CNT_W(2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .pattern_in   (pattern_in),
        .mask_in      (mask_in),
        .overlap_en   (overlap_en),
        .serial_valid (serial_valid),
        .serial_in    (serial_in),
        .count_clr    (count_clr),
        .patt         (patt2),
        .match_count  (match_count2),
        .armed        (armed2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [4:0] pat, input logic [4:0] msk,
                         input logic v, input logic b, input logic clr);
        @(negedge clk);
        load         = ld;
        pattern_in   = pat;
        mask_in      = msk;
        serial_valid = v;
        serial_in    = b;
        count_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [4:0] pat, input logic [4:0] msk, input logic v, input logic b);
        drive(1'b1, pat, msk, v, b, 1'b0);
        check("load patt", {31'd0, patt}, 32'd0);
        check("load armed", {31'd0, armed}, 32'd0);
    endtask

    // bits[n-1] is sent first; exp_p/exp_a give patt/armed after each bit
    task automatic feed(input string tag, input logic [31:0] bits, input int n,
                        input logic [31:0] exp_p, input logic [31:0] exp_a);
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b0, 5'd0, 5'd0, 1'b1, bits[i], 1'b0);
            check({tag, " patt"}, {31'd0, patt}, {31'd0, exp_p[i]});
            check({tag, " armed"}, {31'd0, armed}, {31'd0, exp_a[i]});
        end
    endtask

    initial begin
        logic [4:0] gap_bits;
        reset        = 1'b1;
        load         = 1'b0;
        pattern_in   = '0;
        mask_in      = '0;
        overlap_en   = 1'b1;
        serial_valid = 1'b0;
        serial_in    = 1'b0;
        count_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst patt", {31'd0, patt}, 32'd0);
        check("rst count", {24'd0, match_count}, 32'd0);
        check("rst armed", {31'd0, armed}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // overlap mode
        overlap_en = 1'b1;
        do_load(5'b11011, 5'b11111, 1'b0, 1'b0);
        feed("t1", 32'b11011011, 8, 32'b00001001, 32'b00001111);
        check("t1 count", {24'd0, match_count}, 32'd2);

        // non-overlap mode: second match needs five fresh bits
        overlap_en = 1'b0;
        do_load(5'b11011, 5'b11111, 1'b0, 1'b0);
        feed("t2", 32'b11011011011, 11, 32'b00001000001, 32'b00000000010);
        check("t2 count", {24'd0, match_count}, 32'd4);

        // don't-care mask on bit 2
        overlap_en = 1'b1;
        do_load(5'b11011, 5'b11011, 1'b0, 1'b0);
        feed("t3a", 32'b11111, 5, 32'b00001, 32'b00001);
        do_load(5'b11011, 5'b11011, 1'b0, 1'b0);
        feed("t3b", 32'b01111, 5, 32'b00000, 32'b00001);
        check("t3 count", {24'd0, match_count}, 32'd5);

        // load discards a same-cycle bit; gaps hold everything
        do_load(5'b11011, 5'b11111, 1'b0, 1'b0);
        feed("t4pre", 32'b110, 3, 32'b000, 32'b000);
        do_load(5'b11011, 5'b11111, 1'b1, 1'b1);
        gap_bits = 5'b11011;
        for (int j = 0; j < 5; j++) begin
            drive(1'b0, 5'd0, 5'd0, 1'b1, gap_bits[4-j], 1'b0);
            check("t4 patt", {31'd0, patt}, (j == 4) ? 32'd1 : 32'd0);
            check("t4 armed", {31'd0, armed}, (j == 4) ? 32'd1 : 32'd0);
            drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            check("t4 gap patt", {31'd0, patt}, 32'd0);
            check("t4 gap armed", {31'd0, armed}, (j == 4) ? 32'd1 : 32'd0);
        end
        check("t4 count", {24'd0, match_count}, 32'd6);

        // saturation and clear priority
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        check("t5 clr count", {24'd0, match_count}, 32'd0);
        check("t5 clr count2", {30'd0, match_count2}, 32'd0);
        do_load(5'b11111, 5'b11111, 1'b0, 1'b0);
        feed("t5", 32'b111111111, 9, 32'b000011111, 32'b000011111);
        check("t5 count", {24'd0, match_count}, 32'd5);
        check("t5 sat count2", {30'd0, match_count2}, 32'd3);
        drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        check("t5 clr+match patt", {31'd0, patt}, 32'd1);
        check("t5 clr+match count", {24'd0, match_count}, 32'd0);
        check("t5 clr+match count2", {30'd0, match_count2}, 32'd0);

        // asynchronous reset in ARMED, then no matching without a load
        drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        check("t6 pre patt", {31'd0, patt}, 32'd1);
        check("t6 pre count", {24'd0, match_count}, 32'd1);
        serial_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("t6 async patt", {31'd0, patt}, 32'd0);
        check("t6 async count", {24'd0, match_count}, 32'd0);
        check("t6 async armed", {31'd0, armed}, 32'd0);
        check("t6 async patt2", {31'd0, patt2}, 32'd0);
        check("t6 async armed2", {31'd0, armed2}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        feed("t6", 32'b11111, 5, 32'b00000, 32'b00000);
        check("t6 count", {24'd0, match_count}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
